// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_* : two-bit operation codes carried on op_i
//   - mdu_state_e : control FSM states
//   - mdu_abs : conditional two's-complement negation, used both to take operand
//     magnitudes before dividing and to re-apply signs to the quotient/remainder.
//     Works on a 64-bit container; callers cast the result back to their width,
//     which is exact because negation modulo 2^64 truncates to negation modulo 2^W.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } mdu_state_e;

  function automatic logic [63:0] mdu_abs(input logic [63:0] value, input logic negate);
    return negate ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider datapath working on unsigned magnitudes.
// One quotient bit per step, MSB first; WIDTH steps complete a division.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           capture dividend/divisor, clear partial remainder and counter
//   step           perform one iteration
//   dividend       unsigned dividend magnitude
//   divisor        unsigned divisor magnitude (never zero when stepped)
//   quotient       quotient shift register (valid after WIDTH steps)
//   remainder      partial remainder (final remainder after WIDTH steps)
//   last_iter      high while the step about to be taken is the final one
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_iter
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CNT_W-1:0] cnt_reg;

  // The dividend is shifted out of the top of the quotient register while
  // quotient bits enter at the bottom, so one register serves both roles.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};
  // rem < divisor always holds, so a borrow shows up exactly in diff[WIDTH].
  assign fits    = ~diff[WIDTH];

  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
      cnt_reg <= '0;
    end else if (step) begin
      rem_reg <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_reg <= {quo_reg[WIDTH-2:0], fits};
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the MIPS execute stage.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start_i    request, accepted only while idle (and not cancelled)
//   op_i       MULT / MULTU / DIV / DIVU, sampled with start_i
//   a_i, b_i   rs / rt operands, captured at start
//   cancel_i   abort in-flight operation (flush / exception)
//   busy_o     high in every non-idle state; stalls E and earlier stages
//   done_o     one-cycle pulse while hi_o/lo_o present a fresh result
//   hi_o/lo_o  product high/low, or remainder/quotient
// Multiply latency is MUL_STAGES cycles, divide WIDTH+2, divide-by-zero 1.
module mips_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W    = (MUL_STAGES > 2) ? $clog2(MUL_STAGES) : 1;
  localparam int MUL_LAST = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
  localparam logic [CNT_W-1:0] MUL_LAST_CNT = CNT_W'(MUL_LAST);

  mdu_state_e       state_reg;
  logic [CNT_W-1:0] mul_cnt_reg;
  logic             neg_quo_reg;
  logic             neg_rem_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic               op_div, op_signed;
  logic               a_neg, b_neg, b_zero;
  logic               accept, mul_load, div_load, div_step, div_last;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_final;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag, quo_fix, rem_fix;

  assign op_div    = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
  assign op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign a_neg     = op_signed & a_i[WIDTH-1];
  assign b_neg     = op_signed & b_i[WIDTH-1];
  assign b_zero    = (b_i == '0);

  // Cancel outranks start even in IDLE, so a flushed instruction never begins.
  assign accept   = (state_reg == IDLE) && start_i && !cancel_i;
  assign mul_load = accept && !op_div;
  assign div_load = accept && op_div;
  assign div_step = (state_reg == DIV);

  // Sign- or zero-extension to 2*WIDTH makes one unsigned multiplier exact for
  // both signednesses (the low 2*WIDTH bits of the product are what we keep).
  assign a_ext   = {{WIDTH{a_neg}}, a_i};
  assign b_ext   = {{WIDTH{b_neg}}, b_i};
  assign product = a_ext * b_ext;

  // The multiplier is computed from the live operands in the start cycle, so the
  // first pipeline register is the operand capture. hi/lo form the last stage,
  // leaving MUL_STAGES-1 internal registers for retiming.
  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_final = product;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe_reg [MUL_STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_reg[i] <= '0;
        end else begin
          if (mul_load) pipe_reg[0] <= product;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end

      assign mul_final = pipe_reg[MUL_STAGES-2];
    end
  endgenerate

  // Magnitudes in, signs re-applied in FIX: remainder follows the dividend,
  // quotient is negative when operand signs differ. MIN/-1 wraps to MIN.
  assign a_mag   = WIDTH'(mdu_abs(64'(a_i), a_neg));
  assign b_mag   = WIDTH'(mdu_abs(64'(b_i), b_neg));
  assign quo_fix = WIDTH'(mdu_abs(64'(quo_mag), neg_quo_reg));
  assign rem_fix = WIDTH'(mdu_abs(64'(rem_mag), neg_rem_reg));

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (quo_mag),
    .remainder(rem_mag),
    .last_iter(div_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      mul_cnt_reg <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (state_reg != IDLE && cancel_i) begin
      // Abort: results are only written on entry to DONE, so hi/lo keep
      // the last committed values.
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            neg_quo_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            mul_cnt_reg <= '0;
            if (!op_div) begin
              if (MUL_STAGES == 1) begin
                hi_reg    <= mul_final[2*WIDTH-1:WIDTH];
                lo_reg    <= mul_final[WIDTH-1:0];
                state_reg <= DONE;
              end else begin
                state_reg <= MUL;
              end
            end else if (b_zero) begin
              hi_reg    <= a_i;
              lo_reg    <= '1;
              state_reg <= DONE;
            end else begin
              state_reg <= DIV;
            end
          end
        end
        MUL: begin
          if (mul_cnt_reg == MUL_LAST_CNT) begin
            hi_reg    <= mul_final[2*WIDTH-1:WIDTH];
            lo_reg    <= mul_final[WIDTH-1:0];
            state_reg <= DONE;
          end else begin
            mul_cnt_reg <= mul_cnt_reg + 1'b1;
          end
        end
        DIV: begin
          if (div_last) state_reg <= FIX;
        end
        FIX: begin
          hi_reg    <= rem_fix;
          lo_reg    <= quo_fix;
          state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_reg != IDLE);
  assign done_o = (state_reg == DONE);
  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;
  import mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 32-bit, 2-stage instance
  logic        start = 1'b0, cancel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  // 16-bit, 4-stage instance
  logic        s_start = 1'b0, s_cancel = 1'b0;
  logic [1:0]  s_op = 2'b00;
  logic [15:0] s_a = '0, s_b = '0;
  logic        s_busy, s_done;
  logic [15:0] s_hi, s_lo;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   busy_run = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  mips_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .cancel_i(cancel), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  mips_muldiv_unit #(.WIDTH(16), .MUL_STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .start_i(s_start), .op_i(s_op), .a_i(s_a), .b_i(s_b),
    .cancel_i(s_cancel), .busy_o(s_busy), .done_o(s_done), .hi_o(s_hi), .lo_o(s_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor for the 32-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst || !busy) busy_run = 0;
    else busy_run++;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d (hi=0x%08h lo=0x%08h), required no completion",
                 cyc, hi, lo);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_done_cycle"}, cyc, e.cyc);
        check({e.name, "_busy_cycles"}, busy_run, e.lat);
        $display("txn %-12s hi=0x%08h lo=0x%08h done_cycle=%0d busy_cycles=%0d",
                 e.name, hi, lo, cyc, busy_run);
      end
    end
  end

  // Scoreboard monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (s_done) begin
      if (exp2_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done16: done_o=1 at cycle %0d, required no completion", cyc);
      end else begin
        e = exp2_q.pop_front();
        check({e.name, "_hi"}, {16'h0, s_hi}, e.hi);
        check({e.name, "_lo"}, {16'h0, s_lo}, e.lo);
        check({e.name, "_done_cycle"}, cyc, e.cyc);
        $display("txn %-12s hi=0x%04h lo=0x%04h done_cycle=%0d", e.name, s_hi, s_lo, cyc);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: busy_o=1 after 100 cycles, required 0", name);
    end
  endtask

  // Issue one op, queue its expected result, optionally pulse a stray start
  // pulse_at cycles after the start edge, then wait for the unit to go idle.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat, input int pulse_at);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;
    e.name = name; e.hi = ehi; e.lo = elo; e.cyc = cyc + lat - 1; e.lat = lat;
    exp_q.push_back(e);
    start = 1'b0; a = $urandom; b = $urandom;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(negedge clk);
      start = 1'b1; op = MDU_MULTU;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(name);
  endtask

  initial begin
    exp_t e;
    int   n;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy16", {31'b0, s_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue("mult_neg",   MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 2, 0);
    issue("multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 0);
    issue("mult_ext",   MDU_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 2, 0);
    issue("div_neg",    MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0);
    issue("div_negb",   MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34, 0);
    issue("divu",       MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34, 0);
    issue("div_minm1",  MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34, 0);
    issue("divu_zero",  MDU_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1, 0);
    issue("div_zero",   MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1, 0);
    issue("divu_ignst", MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34, 5);

    // start and cancel together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = MDU_DIVU; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    check("idle_cancel_busy", {31'b0, busy}, 32'd0);
    start = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clk);

    // cancel at cycle 10 of a divide
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cancel_pre_busy", {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    cancel = 1'b0;
    check("cancel_hi", hi, 32'd2);
    check("cancel_lo", lo, 32'd14);
    repeat (40) @(negedge clk);

    // asynchronous reset between edges in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset_busy", {31'b0, busy}, 32'd0);
    check("areset_hi", hi, 32'd0);
    check("areset_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("multu_post", MDU_MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 2, 0);

    // 16-bit, 4-stage smoke
    @(negedge clk);
    s_start = 1'b1; s_op = MDU_MULT; s_a = 16'hFFFE; s_b = 16'd3;
    @(posedge clk); #1;
    e.name = "mult16"; e.hi = 32'h0000FFFF; e.lo = 32'h0000FFFA; e.cyc = cyc + 3; e.lat = 4;
    exp2_q.push_back(e);
    s_start = 1'b0; s_a = 16'h1234; s_b = 16'h5678;
    n = 0;
    @(negedge clk);
    while (s_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (s_busy) begin
      checks++;
      fails++;
      $display("FAIL mult16_timeout: busy_o=1 after 100 cycles, required 0");
    end

    repeat (5) @(negedge clk);
    check("pending32", exp_q.size(), 32'd0);
    check("pending16", exp2_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
